dyn_brnch_pred_tournament_param: RTL and testbench
==================================================

Name: dyn_brnch_pred_tournament_param

Overview:
- Parametrised next-generation tournament predictor for the 32b MIPS pipeline: gshare global component, per-branch local-history component, and a saturating-counter chooser.
- Predicts in IF for the branch presented that cycle, captures that branch's prediction context, and trains all tables from the captured context when the branch resolves in ID.
- Adds configurable counter/history widths, registered mispredict flag, and saturating performance counters.

Parameters:
- PC_IDX_W, 5, low PC bits indexing LHT, chooser and gshare hash (table depth 2^PC_IDX_W)
- GHR_W, 5, global history length; legal 1..PC_IDX_W, zero-extended to PC_IDX_W before XOR
- LHIST_W, 5, local history length per LHT entry; local PHT depth 2^LHIST_W
- CTR_W, 2, width of every saturating counter (global PHT, local PHT, chooser); legal 1..4
- STAT_W, 16, width of branch/mispredict statistics counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- brch_pc_idx  in  PC_IDX_W  low PC bits of the IF branch
- brch_valid_if  in  1  branch instruction in IF this cycle
- brch_resolve_id  in  1  branch in ID resolving this cycle
- brch_hazard_stall  in  1  pipeline stall; freezes capture and update
- actual_brch_result  in  1  resolved direction, valid with brch_resolve_id
- predict_br_taken  out  1  final prediction, gated by brch_valid_if
- mispredict  out  1  registered: previous update was mispredicted
- stat_branches  out  STAT_W  resolved-branch count, saturating
- stat_mispredicts  out  STAT_W  mispredict count, saturating

Behaviour:
- Reset (asynchronous, active-low): GHR=0; all LHT entries=0; global/local PHT counters=2^(CTR_W-1)-1 (weakly not-taken); chooser counters=2^(CTR_W-1)-1 (weakly local); context valid=0; mispredict=0; stats=0. Counters MSB=1 means taken/choose-global.
- Predict (combinational, zero latency): g_idx = brch_pc_idx XOR zext(GHR); p_g = MSB gPHT[g_idx]; lh = LHT[brch_pc_idx]; p_l = MSB lPHT[lh]; sel = MSB chooser[brch_pc_idx]; predict_br_taken = (sel ? p_g : p_l) & brch_valid_if.
- Capture: on clk when brch_valid_if & !brch_hazard_stall: store pc_idx, g_idx, lh, p_g, p_l, final prediction; ctx_valid<=1. Stall holds context unchanged.
- Update: upd = brch_resolve_id & !brch_hazard_stall & ctx_valid. On upd, using captured context only:
  - gPHT[g_idx], lPHT[lh] saturating inc if actual=1 else dec; no wrap at 0 or 2^CTR_W-1.
  - chooser[pc_idx] updated only if p_g != p_l: inc if p_g correct, dec if p_l correct.
  - GHR <= {GHR[GHR_W-2:0], actual} (GHR_W=1: GHR<=actual); LHT[pc_idx] shifts in actual identically.
  - mispredict <= (final != actual); stat_branches+1 saturating; stat_mispredicts+1 if mispredict, saturating at all-ones.
  - ctx_valid <= 0 unless a new capture occurs same edge.
- Without upd: mispredict<=0; stats hold.
- brch_resolve_id with ctx_valid=0: ignored (no table, stat or mispredict change).
- Simultaneous capture and update same edge: IF prediction uses pre-update tables/GHR (no bypass); capture overwrites context after update consumed old one; ctx_valid stays 1.
- Stall overrides both capture and update; tables, GHR, stats frozen.
- Reset mid-operation: all state returns to reset values immediately, pending context discarded.

Test Plan:
- Reset defaults: after rst_n release, brch_valid_if=1 any pc_idx -> predict_br_taken=0, stats=0, mispredict=0.
- Always-taken branch pc_idx=3, 4 predict/resolve pairs actual=1 -> prediction flips to 1 by the 3rd pair; mispredict=1 cycle after 1st and 2nd resolves only; stat_branches=4, stat_mispredicts=2.
- Saturation: CTR_W=2, 10 taken resolves on same lPHT entry -> counter holds 3; one not-taken -> prediction still taken.
- Stall: brch_hazard_stall=1 during resolve -> no GHR/stat change; deassert next cycle -> update applied once.
- Orphan resolve: brch_resolve_id=1 with no prior capture -> stats remain 0, mispredict stays 0.
- Alternating T/N pattern on pc_idx=7 with LHIST_W=5 -> local component learns, chooser selects local, mispredicts stop within 40 branches; stat_mispredicts saturates at 2^STAT_W-1 in a STAT_W=4 overflow run.

Source files
------------

// File: rtl/dyn_brnch_pred_tournament_param.sv
// Tournament branch predictor: gshare global component, per-branch local
// history component and a per-PC chooser. Predicts in IF, remembers the
// prediction context, and trains every table from that context at ID resolve.
module dyn_brnch_pred_tournament_param #(
  parameter int PC_IDX_W = 5,
  parameter int GHR_W    = 5,
  parameter int LHIST_W  = 5,
  parameter int CTR_W    = 2,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_IDX_W-1:0] brch_pc_idx,
  input  logic                brch_valid_if,
  input  logic                brch_resolve_id,
  input  logic                brch_hazard_stall,
  input  logic                actual_brch_result,
  output logic                predict_br_taken,
  output logic                mispredict,
  output logic [STAT_W-1:0]   stat_branches,
  output logic [STAT_W-1:0]   stat_mispredicts
);

  localparam int PC_DEPTH   = 1 << PC_IDX_W;
  localparam int LPHT_DEPTH = 1 << LHIST_W;
  // Weakly not-taken / weakly local: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Saturating up/down step; never wraps at either end.
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    logic [CTR_W-1:0] r;
    r = c;
    if (up) begin
      if (c != CTR_MAX) r = c + CTR_W'(1);
      else              r = c;
    end else begin
      if (c != CTR_ZERO) r = c - CTR_W'(1);
      else               r = c;
    end
    return r;
  endfunction

  // Saturating statistics increment.
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
    logic [STAT_W-1:0] r;
    if (s != STAT_MAX) r = s + STAT_W'(1);
    else               r = s;
    return r;
  endfunction

  // Prediction tables and history
  logic [CTR_W-1:0]    gpht_q    [PC_DEPTH];
  logic [CTR_W-1:0]    lpht_q    [LPHT_DEPTH];
  logic [CTR_W-1:0]    chooser_q [PC_DEPTH];
  logic [LHIST_W-1:0]  lht_q     [PC_DEPTH];
  logic [GHR_W-1:0]    ghr_q;

  // Captured prediction context of the branch that will resolve next
  logic                ctx_valid_q;
  logic [PC_IDX_W-1:0] ctx_pc_q;
  logic [PC_IDX_W-1:0] ctx_gidx_q;
  logic [LHIST_W-1:0]  ctx_lh_q;
  logic                ctx_pg_q;
  logic                ctx_pl_q;
  logic                ctx_pred_q;

  logic                misp_q;
  logic [STAT_W-1:0]   stat_br_q;
  logic [STAT_W-1:0]   stat_mis_q;

  // Combinational lookup signals
  logic [PC_IDX_W-1:0] ghr_ext;
  logic [PC_IDX_W-1:0] g_idx;
  logic [LHIST_W-1:0]  lh;
  logic                p_g;
  logic                p_l;
  logic                sel_g;
  logic                pred_raw;
  logic                cap;
  logic                upd;
  logic [GHR_W:0]      ghr_shift;
  logic [GHR_W-1:0]    ghr_d;
  logic [LHIST_W:0]    lht_shift;
  logic [LHIST_W-1:0]  lht_d;

  // Zero-latency lookup of all three components for the IF branch.
  always_comb begin
    ghr_ext              = '0;
    ghr_ext[GHR_W-1:0]   = ghr_q;
    g_idx                = brch_pc_idx ^ ghr_ext;
    lh                   = lht_q[brch_pc_idx];
    p_g                  = gpht_q[g_idx][CTR_W-1];
    p_l                  = lpht_q[lh][CTR_W-1];
    sel_g                = chooser_q[brch_pc_idx][CTR_W-1];
    pred_raw             = sel_g ? p_g : p_l;
    predict_br_taken     = pred_raw & brch_valid_if;
  end

  // Capture/update qualifiers and shifted histories (shift in resolved outcome).
  always_comb begin
    cap       = brch_valid_if & ~brch_hazard_stall;
    upd       = brch_resolve_id & ~brch_hazard_stall & ctx_valid_q;
    ghr_shift = {ghr_q, actual_brch_result};
    ghr_d     = ghr_shift[GHR_W-1:0];
    lht_shift = {lht_q[ctx_pc_q], actual_brch_result};
    lht_d     = lht_shift[LHIST_W-1:0];
  end

  // Context register: a new capture wins over the clear caused by an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_valid_q <= 1'b0;
      ctx_pc_q    <= '0;
      ctx_gidx_q  <= '0;
      ctx_lh_q    <= '0;
      ctx_pg_q    <= 1'b0;
      ctx_pl_q    <= 1'b0;
      ctx_pred_q  <= 1'b0;
    end else if (cap) begin
      ctx_valid_q <= 1'b1;
      ctx_pc_q    <= brch_pc_idx;
      ctx_gidx_q  <= g_idx;
      ctx_lh_q    <= lh;
      ctx_pg_q    <= p_g;
      ctx_pl_q    <= p_l;
      ctx_pred_q  <= pred_raw;
    end else if (upd) begin
      ctx_valid_q <= 1'b0;
    end
  end

  // Table training from the captured context only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PC_DEPTH; i++) begin
        gpht_q[i]    <= CTR_INIT;
        chooser_q[i] <= CTR_INIT;
        lht_q[i]     <= '0;
      end
      for (int j = 0; j < LPHT_DEPTH; j++) begin
        lpht_q[j] <= CTR_INIT;
      end
    end else if (upd) begin
      gpht_q[ctx_gidx_q] <= ctr_step(gpht_q[ctx_gidx_q], actual_brch_result);
      lpht_q[ctx_lh_q]   <= ctr_step(lpht_q[ctx_lh_q], actual_brch_result);
      lht_q[ctx_pc_q]    <= lht_d;
      // Chooser only learns when the components disagreed.
      if (ctx_pg_q != ctx_pl_q) begin
        chooser_q[ctx_pc_q] <= ctr_step(chooser_q[ctx_pc_q], ctx_pg_q == actual_brch_result);
      end
    end
  end

  // Global history, registered mispredict flag and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q      <= '0;
      misp_q     <= 1'b0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (upd) begin
      ghr_q     <= ghr_d;
      misp_q    <= (ctx_pred_q != actual_brch_result);
      stat_br_q <= stat_inc(stat_br_q);
      if (ctx_pred_q != actual_brch_result) begin
        stat_mis_q <= stat_inc(stat_mis_q);
      end
    end else begin
      misp_q <= 1'b0;
    end
  end

  assign mispredict       = misp_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_dyn_brnch_pred_tournament_param.sv
// Scoreboard bench for the tournament predictor. The driver pushes the
// expected outputs for each cycle it drives; a monitor on the falling edge
// pops and compares. Bench configuration: GHR_W=2, LHIST_W=1, CTR_W=2,
// STAT_W=4 so every expected value below can be traced by hand.
module tb_dyn_brnch_pred_tournament_param;

  localparam int PW = 5;
  localparam int GW = 2;
  localparam int LW = 1;
  localparam int CW = 2;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] brch_pc_idx = '0;
  logic          brch_valid_if = 1'b0;
  logic          brch_resolve_id = 1'b0;
  logic          brch_hazard_stall = 1'b0;
  logic          actual_brch_result = 1'b0;
  logic          predict_br_taken;
  logic          mispredict;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_mispredicts;

  dyn_brnch_pred_tournament_param #(
    .PC_IDX_W(PW), .GHR_W(GW), .LHIST_W(LW), .CTR_W(CW), .STAT_W(SW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .brch_pc_idx        (brch_pc_idx),
    .brch_valid_if      (brch_valid_if),
    .brch_resolve_id    (brch_resolve_id),
    .brch_hazard_stall  (brch_hazard_stall),
    .actual_brch_result (actual_brch_result),
    .predict_br_taken   (predict_br_taken),
    .mispredict         (mispredict),
    .stat_branches      (stat_branches),
    .stat_mispredicts   (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pred;
    logic          misp;
    logic [SW-1:0] br;
    logic [SW-1:0] mis;
    int            id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  // Drive one cycle of inputs and queue what the outputs must show this cycle.
  task automatic step(input logic v, input logic [PW-1:0] pc, input logic res,
                      input logic act, input logic stl, input logic ep,
                      input logic em, input int eb, input int emis);
    exp_t e;
    @(posedge clk); #1;
    brch_valid_if      = v;
    brch_pc_idx        = pc;
    brch_resolve_id    = res;
    actual_brch_result = act;
    brch_hazard_stall  = stl;
    e.pred = ep;
    e.misp = em;
    e.br   = SW'(eb);
    e.mis  = SW'(emis);
    e.id   = step_id;
    step_id++;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n              = 1'b0;
    brch_valid_if      = 1'b0;
    brch_pc_idx        = '0;
    brch_resolve_id    = 1'b0;
    actual_brch_result = 1'b0;
    brch_hazard_stall  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (predict_br_taken !== mon_e.pred) begin
        errors++;
        $display("FAIL pred step=%0d got=%0b exp=%0b", mon_e.id, predict_br_taken, mon_e.pred);
      end
      checks++;
      if (mispredict !== mon_e.misp) begin
        errors++;
        $display("FAIL mispredict step=%0d got=%0b exp=%0b", mon_e.id, mispredict, mon_e.misp);
      end
      checks++;
      if (stat_branches !== mon_e.br) begin
        errors++;
        $display("FAIL stat_branches step=%0d got=%0d exp=%0d", mon_e.id, stat_branches, mon_e.br);
      end
      checks++;
      if (stat_mispredicts !== mon_e.mis) begin
        errors++;
        $display("FAIL stat_mispredicts step=%0d got=%0d exp=%0d", mon_e.id, stat_mispredicts, mon_e.mis);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Per-pair expectations for the always-taken run on pc 3.
  logic [3:0] bt_pred;
  logic [3:0] bt_misp;
  int         bt_mis [4];

  initial begin
    bt_pred = 4'b1100;   // bit p-1: prediction of pair p
    bt_misp = 4'b0110;   // bit p-1: flag visible while pair p predicts
    bt_mis[0] = 0; bt_mis[1] = 1; bt_mis[2] = 2; bt_mis[3] = 2;

    // Reset defaults: every PC predicts not-taken, stats clear.
    do_reset();
    step(1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Capture and update on the same edge: context stays valid for the second resolve.
    do_reset();
    step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2);

    // Always-taken branch on pc 3: flips to taken on the 3rd pair.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, bt_pred[p], bt_misp[p], p, bt_mis[p]);
      step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, p, bt_mis[p]);
    end
    // Keep training: counters must saturate, not wrap back to not-taken.
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4 + k, 2);
      step(1'b0, 5'd0, 1'b1, (k != 6), 1'b0, 1'b0, 1'b0, 4 + k, 2);
    end
    // One not-taken was a mispredict; the branch still predicts taken.
    step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11, 3);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11, 3);
    step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12, 3);

    // Reset with a context pending: the following resolve is an orphan.
    do_reset();
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Stall freezes update, then a single update lands; stalled capture is dropped.
    do_reset();
    step(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
    step(1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);

    // Alternating T/N on pc 7: only the first branch mispredicts.
    do_reset();
    for (int p = 1; p <= 8; p++) begin
      step(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, (p > 2) && (p % 2 == 1), (p == 2), p - 1, (p > 1) ? 1 : 0);
      step(1'b0, 5'd0, 1'b1, (p % 2 == 1), 1'b0, 1'b0, 1'b0, p - 1, (p > 1) ? 1 : 0);
    end

    // Overflow: fresh PCs all share local entry 0, alternating outcome mispredicts every time.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(1'b1, PW'(k), 1'b0, 1'b0, 1'b0, (k % 2 == 1), (k > 0), (k > 15) ? 15 : k, (k > 15) ? 15 : k);
      step(1'b0, 5'd0, 1'b1, (k % 2 == 0), 1'b0, 1'b0, 1'b0, (k > 15) ? 15 : k, (k > 15) ? 15 : k);
    end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15, 15);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
